// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: start/busy/done handshake and operand/result bus of the chunked adder.
interface seq_chunk_adder_if #(parameter int WIDTH = 1024);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    modport master(output start, sub, in1, in2, input busy, done, out, carry_out);
    modport slave(input start, sub, in1, in2, output busy, done, out, carry_out);
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit add/sub, CHUNK bits per clock with a registered carry.
module seq_chunk_adder #(
    parameter int WIDTH = 1024,
    parameter int CHUNK = 64
) (
    input  logic              clk,
    input  logic              rst,
    seq_chunk_adder_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = NCH > 1 ? $clog2(NCH) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_out;
    logic             r_sub;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_co;
    logic [IW-1:0]    r_idx;
    logic [CHUNK:0]   w_s;
    logic [WIDTH-1:0] w_res;
    logic             w_last;

    // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
    always_comb begin
        w_s = {1'b0, r_a[r_idx*CHUNK +: CHUNK]}
            + {1'b0, r_b[r_idx*CHUNK +: CHUNK] ^ {CHUNK{r_sub}}}
            + {{CHUNK{1'b0}}, r_carry};
        w_res = r_res;
        w_res[r_idx*CHUNK +: CHUNK] = w_s[CHUNK-1:0];
    end

    assign w_last = r_idx == IW'(NCH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_out   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_co    <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.start) begin
                    r_a     <= bus.in1;
                    r_b     <= bus.in2;
                    r_sub   <= bus.sub;
                    r_carry <= bus.sub;
                    r_idx   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= RUN;
                end
            end else begin
                r_res   <= w_res;
                r_carry <= w_s[CHUNK];
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_out   <= w_res;
                    r_co    <= w_s[CHUNK];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= IDLE;
                end
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.out       = r_out;
    assign bus.carry_out = r_co;
endmodule
